// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file write-back arbiter.
// Used by wb_arbiter and its long-result buffer wb_fifo.
package wb_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int STARVE_LIMIT_DEF = 8;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Long-result buffer: synchronous FIFO of wb_entry_t, no fall-through.
// Push while full and pop while empty are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t wdata,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wb_entry_t      mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; contents are only meaningful below cnt_q.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-port driver: merges ALU and long-latency results.
// Optional WB_BYPASS_EN adds same-cycle write-to-read forwarding.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    input  logic                  issue_valid,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    output logic [31:0]           busy_mask,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wdata
`ifdef WB_BYPASS_EN
    ,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic [XLEN-1:0]       rf_rdata1,
    input  logic [XLEN-1:0]       rf_rdata2,
    output logic [XLEN-1:0]       fwd_data1,
    output logic [XLEN-1:0]       fwd_data2
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             lsu_entry;
    wb_entry_t             fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  fifo_push;
    wb_src_e               src;
    logic                  at_limit;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [31:0]           busy_q, busy_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;

    assign lsu_entry.rd   = lsu_rd;
    assign lsu_entry.data = lsu_data;

    assign at_limit  = (cnt_q == CW'(STARVE_LIMIT));
    assign alu_ready = !at_limit;
    assign lsu_ready = !fifo_full;
    assign fifo_push = lsu_valid && !fifo_full;
    assign fifo_pop  = (src == SRC_FIFO);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (lsu_entry),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Pick this cycle's write source: ALU first unless it is being held off.
    always_comb begin
        src = SRC_NONE;
        if (alu_valid && alu_ready) src = SRC_ALU;
        else if (!fifo_empty)       src = SRC_FIFO;
    end

    // Registered write port next state; rd 0 is consumed without a write.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        unique case (src)
            SRC_ALU: begin
                rf_we_d    = (alu_rd != '0);
                rf_rd_d    = alu_rd;
                rf_wdata_d = alu_data;
            end
            SRC_FIFO: begin
                rf_we_d    = (fifo_head.rd != '0);
                rf_rd_d    = fifo_head.rd;
                rf_wdata_d = fifo_head.data;
            end
            default: ;
        endcase
    end

    // Starvation counter: age of an unserved FIFO head, saturating.
    always_comb begin
        cnt_d = cnt_q;
        if (fifo_empty || fifo_pop) cnt_d = '0;
        else if (!at_limit)         cnt_d = cnt_q + CW'(1);
    end

    // Busy scoreboard: clear on long write-back, set on long issue (set wins).
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
        if (issue_valid && issue_long && issue_rd != '0)
            busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State registers for the write port, counter and scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
            busy_q     <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_rd     = rf_rd_q;
    assign rf_wdata  = rf_wdata_q;
    assign busy_mask = busy_q;

`ifdef WB_BYPASS_EN
    assign fwd_data1 = (rf_we_q && rf_rd_q == rs1 && rs1 != '0) ?
                       rf_wdata_q : rf_rdata1;
    assign fwd_data2 = (rf_we_q && rf_rd_q == rs2 && rs2 != '0) ?
                       rf_wdata_q : rf_rdata2;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus a
// cycle model that queues every expected write-port value.
module tb_wb_arbiter;

    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid, issue_long;
    logic [4:0]  issue_rd;
    logic [31:0] busy_mask;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_rdata1, rf_rdata2, fwd_data1, fwd_data2;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .issue_valid (issue_valid),
        .issue_long  (issue_long),
        .issue_rd    (issue_rd),
        .busy_mask   (busy_mask),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata)
`ifdef WB_BYPASS_EN
        ,
        .rs1         (rs1),
        .rs2         (rs2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .fwd_data1   (fwd_data1),
        .fwd_data2   (fwd_data2)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic alu_new();
        alu_rd   = 5'($urandom_range(1, 31));
        alu_data = $urandom;
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
    } rec_t;

    ent_t        mq[$];
    rec_t        exp_q[$];
    int          m_cnt;
    logic [31:0] m_busy;

    // Reference model: evaluates each edge from the driven stimulus.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            exp_q.delete();
            m_cnt  = 0;
            m_busy = '0;
        end else begin
            bit   a_take, f_take, l_take;
            rec_t r;
            a_take = alu_valid && (m_cnt != STARVE);
            f_take = !a_take && (mq.size() != 0);
            l_take = lsu_valid && (mq.size() < DEPTH);
            r.we   = 1'b0;
            r.rd   = '0;
            r.data = '0;
            if (a_take) begin
                r.we = (alu_rd != 0); r.rd = alu_rd; r.data = alu_data;
            end else if (f_take) begin
                r.we = (mq[0].rd != 0); r.rd = mq[0].rd;
                r.data = mq[0].data;
            end
            exp_q.push_back(r);
            if (f_take || mq.size() == 0) m_cnt = 0;
            else if (m_cnt < STARVE)      m_cnt++;
            if (f_take) begin
                m_busy[mq[0].rd] = 1'b0;
                void'(mq.pop_front());
            end
            if (l_take) mq.push_back('{lsu_rd, lsu_data});
            if (issue_valid && issue_long && issue_rd != 0)
                m_busy[issue_rd] = 1'b1;
        end
    end

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_q.size() != 0) begin
                rec_t r;
                r = exp_q.pop_front();
                check("sb_rf_we", rf_we, r.we);
                if (r.we) begin
                    check("sb_rf_rd", rf_rd, r.rd);
                    check("sb_rf_wdata", rf_wdata, r.data);
                end
            end
            check("sb_busy", busy_mask, m_busy);
            check("sb_alu_ready", alu_ready, m_cnt != STARVE);
            check("sb_lsu_ready", lsu_ready, mq.size() < DEPTH);
        end
    end

    initial begin
        int w;
        rst_n = 1'b0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        issue_valid = 0; issue_long = 0; issue_rd = 0;
`ifdef WB_BYPASS_EN
        rs1 = 0; rs2 = 0; rf_rdata1 = 0; rf_rdata2 = 0;
`endif
        repeat (3) cyc();
        rst_n = 1'b1;
        check("rst_rf_we", rf_we, 0);
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_busy", busy_mask, 0);
        check("rst_alu_ready", alu_ready, 1);
        check("rst_lsu_ready", lsu_ready, 1);

        // ALU path
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        cyc();
        alu_valid = 0;
        check("alu_we", rf_we, 1);
        check("alu_rd", rf_rd, 5);
        check("alu_data", rf_wdata, 32'hDEADBEEF);
        check("alu_busy", busy_mask, 0);

        // Scoreboard set, long write-back, clear
        issue_valid = 1; issue_long = 1; issue_rd = 7;
        cyc();
        issue_valid = 0;
        check("busy7_set", busy_mask[7], 1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h1234;
        cyc();
        lsu_valid = 0;
        check("lsu_no_fallthru", rf_we, 0);
        cyc();
        check("lsu_we", rf_we, 1);
        check("lsu_rd", rf_rd, 7);
        check("lsu_data", rf_wdata, 32'h1234);
        check("busy7_clr", busy_mask[7], 0);

        // Long result to x0 is consumed silently
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h55;
        cyc();
        lsu_valid = 0;
        cyc();
        check("rd0_we", rf_we, 0);
        cyc();
        check("rd0_popped_we", rf_we, 0);

        // FIFO full under ALU pressure
        alu_valid = 1;
        for (int k = 0; k < 4; k++) begin
            check("full_pre_ready", lsu_ready, 1);
            lsu_valid = 1; lsu_rd = 5'(10 + k); lsu_data = 32'(100 + k);
            alu_new();
            cyc();
        end
        check("full_after4", lsu_ready, 0);
        lsu_rd = 20; lsu_data = 32'hF1F7;
        w = 0;
        while (!lsu_ready && w < 30) begin
            alu_new();
            cyc();
            w++;
        end
        check("fifth_wait_bound", w < 30, 1);
        alu_new();
        cyc();
        lsu_valid = 0;
        alu_valid = 0;
        repeat (8) cyc();
        check("drained_ready", lsu_ready, 1);

        // Starvation: ALU held off after exactly STARVE cycles
        alu_valid = 1; alu_new();
        lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hCAFE0012;
        cyc();
        lsu_valid = 0;
        for (int i = 0; i < STARVE; i++) begin
            check("starve_rdy", alu_ready, 1);
            alu_new();
            cyc();
        end
        check("starve_drop", alu_ready, 0);
        cyc();
        check("starve_we", rf_we, 1);
        check("starve_rd", rf_rd, 12);
        check("starve_data", rf_wdata, 32'hCAFE0012);
        check("starve_back", alu_ready, 1);
        alu_valid = 0;
        repeat (2) cyc();

        // Set/clear collision on the same register
        issue_valid = 1; issue_long = 1; issue_rd = 3;
        cyc();
        issue_valid = 0;
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h33;
        cyc();
        lsu_valid = 0;
        issue_valid = 1; issue_rd = 3;
        cyc();
        issue_valid = 0;
        check("coll_we", rf_we, 1);
        check("coll_rd", rf_rd, 3);
        check("coll_busy3", busy_mask[3], 1);

        // Reset mid-operation flushes pending long work
        issue_valid = 1; issue_rd = 8;
        lsu_valid = 1; lsu_rd = 8; lsu_data = 32'h88;
        cyc();
        issue_valid = 0; lsu_valid = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_mask, 0);
        check("mid_rst_we", rf_we, 0);
        check("mid_rst_lsu_ready", lsu_ready, 1);
        cyc();
        rst_n = 1'b1;
        cyc();
        check("mid_rst_flushed", rf_we, 0);

`ifdef WB_BYPASS_EN
        alu_valid = 1; alu_rd = 9; alu_data = 32'hA5A5A5A5;
        cyc();
        alu_valid = 0;
        rs1 = 9; rf_rdata1 = 0; rs2 = 4; rf_rdata2 = 32'h44;
        #1;
        check("byp_fwd1", fwd_data1, 32'hA5A5A5A5);
        check("byp_nomatch2", fwd_data2, 32'h44);
        rs1 = 0; rf_rdata1 = 32'h1111;
        #1;
        check("byp_x0", fwd_data1, 32'h1111);
`endif

        repeat (3) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
